// File: rtl/multi_way_registered_multiplexer_if.sv
// Handshake bundle for multi_way_registered_multiplexer.
//   Upstream side : in_data (channel i at [i*WIDTH +: WIDTH]), in_valid, in_ready
//   Control       : mode (0 fixed select, 1 round-robin), select
//   Downstream    : out_data, out_valid, out_ready, out_channel
// master = the environment driving channels/consumer, slave = the mux.
interface multi_way_registered_multiplexer_if #(
  parameter int WIDTH = 32,
  parameter int WAYS  = 4
);
  localparam int SEL_WIDTH = $clog2(WAYS);

  logic [WAYS*WIDTH-1:0] in_data;
  logic [WAYS-1:0]       in_valid;
  logic [WAYS-1:0]       in_ready;
  logic                  mode;
  logic [SEL_WIDTH-1:0]  select;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [SEL_WIDTH-1:0]  out_channel;

  modport master (
    output in_data, in_valid, mode, select, out_ready,
    input  in_ready, out_data, out_valid, out_channel
  );

  modport slave (
    input  in_data, in_valid, mode, select, out_ready,
    output in_ready, out_data, out_valid, out_channel
  );
endinterface

// File: rtl/multi_way_registered_multiplexer.sv
// WAYS-to-1 registered multiplexer with valid/ready handshake.
// Fixed-select or round-robin arbitration picks one requesting channel and
// loads it into a single-entry output register; the register drains and
// refills in the same cycle, so throughput is one word per clock.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high
//   bus   - multi_way_registered_multiplexer_if.slave (channels, control, output)

// Per-channel slice: raises this channel's in_ready when it holds the grant
// and masks its data so the output mux is a plain OR of all lanes.
module multi_way_registered_multiplexer_lane #(
  parameter int WIDTH     = 32,
  parameter int SEL_WIDTH = 2,
  parameter int LANE      = 0
) (
  input  logic                 en,
  input  logic [SEL_WIDTH-1:0] grant,
  input  logic [WIDTH-1:0]     data,
  output logic                 ready,
  output logic [WIDTH-1:0]     data_masked
);
  assign ready       = en & (grant == SEL_WIDTH'(LANE));
  assign data_masked = data & {WIDTH{ready}};
endmodule

module multi_way_registered_multiplexer #(
  parameter int WIDTH = 32,
  parameter int WAYS  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  multi_way_registered_multiplexer_if.slave bus
);
  localparam int SEL_WIDTH = $clog2(WAYS);
  localparam int SEL_SPAN  = 1 << SEL_WIDTH;

  logic [WIDTH-1:0]     out_data_q,    out_data_d;
  logic                 out_valid_q,   out_valid_d;
  logic [SEL_WIDTH-1:0] out_channel_q, out_channel_d;
  logic [SEL_WIDTH-1:0] rr_pointer_q,  rr_pointer_d;

  logic                 load_en;
  logic                 grant_valid;
  logic [SEL_WIDTH-1:0] grant;
  logic                 lane_en;
  logic                 transfer;
  logic [SEL_WIDTH:0]   rr_idx;
  logic [SEL_SPAN-1:0]  valid_ext;
  logic [WIDTH-1:0]     mux_data;

  logic [WAYS-1:0][WIDTH-1:0] lane_data;
  logic [WAYS-1:0][WIDTH-1:0] lane_masked;
  logic [WAYS-1:0]            lane_ready;

  assign lane_data = bus.in_data;
  assign load_en   = ~out_valid_q | bus.out_ready;

  // in_ready must read zero while reset is held, even though the emptied
  // register would otherwise make load_en true.
  assign lane_en  = load_en & grant_valid & ~reset;
  assign transfer = lane_en;

  // Arbitration. Fixed mode zero-extends in_valid to the full select range so
  // out-of-range select values land on a zero bit and never grant.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    rr_idx      = '0;
    valid_ext   = '0;
    valid_ext[WAYS-1:0] = bus.in_valid;
    if (!bus.mode) begin
      grant       = bus.select;
      grant_valid = valid_ext[bus.select];
    end else begin
      // Walk from the farthest offset back to rr_pointer so the nearest
      // requester (in pointer order) is the last, winning assignment.
      for (int k = WAYS - 1; k >= 0; k--) begin
        rr_idx = {1'b0, rr_pointer_q} + (SEL_WIDTH+1)'(k);
        if (rr_idx >= (SEL_WIDTH+1)'(WAYS))
          rr_idx = rr_idx - (SEL_WIDTH+1)'(WAYS);
        if (valid_ext[rr_idx[SEL_WIDTH-1:0]]) begin
          grant       = rr_idx[SEL_WIDTH-1:0];
          grant_valid = 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < WAYS; i++) begin : g_lane
    multi_way_registered_multiplexer_lane #(
      .WIDTH     (WIDTH),
      .SEL_WIDTH (SEL_WIDTH),
      .LANE      (i)
    ) u_lane (
      .en          (lane_en),
      .grant       (grant),
      .data        (lane_data[i]),
      .ready       (lane_ready[i]),
      .data_masked (lane_masked[i])
    );
  end

  assign bus.in_ready = lane_ready;

  // At most one lane is unmasked, so OR-ing them selects the granted word.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < WAYS; i++) mux_data = mux_data | lane_masked[i];
  end

  always_comb begin
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    out_valid_d   = out_valid_q;
    rr_pointer_d  = rr_pointer_q;
    if (transfer) begin
      out_data_d    = mux_data;
      out_channel_d = grant;
      out_valid_d   = 1'b1;
      if (bus.mode)
        rr_pointer_d = (grant == SEL_WIDTH'(WAYS - 1)) ? '0 : grant + 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_channel_q <= '0;
      rr_pointer_q  <= '0;
    end else begin
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_channel_q <= out_channel_d;
      rr_pointer_q  <= rr_pointer_d;
    end
  end

  assign bus.out_data    = out_data_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_channel = out_channel_q;
endmodule

// File: tb/tb_multi_way_registered_multiplexer.sv
module tb_multi_way_registered_multiplexer;
  localparam int W = 32;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multi_way_registered_multiplexer_if #(.WIDTH(W), .WAYS(N)) bus0 ();
  multi_way_registered_multiplexer_if #(.WIDTH(8), .WAYS(3)) bus1 ();

  multi_way_registered_multiplexer #(.WIDTH(W), .WAYS(N)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  multi_way_registered_multiplexer #(.WIDTH(8), .WAYS(3)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  ch;
  } exp_t;

  exp_t       sb[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  logic       m_ov;
  logic [1:0] m_rr;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  // One clock of the 4-way DUT: predict grant from the bench's own model,
  // check in_ready and the output register against the scoreboard, then
  // advance the model to match the coming edge.
  task automatic cycle();
    logic       gv;
    int         g;
    logic       le;
    logic [3:0] er;
    exp_t       e;
    @(negedge clk);
    gv = 1'b0;
    g  = 0;
    if (!bus0.mode) begin
      g  = int'(bus0.select);
      gv = bus0.in_valid[g];
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (int'(m_rr) + k) % N;
        if (!gv && bus0.in_valid[i]) begin gv = 1'b1; g = i; end
      end
    end
    le = !m_ov || bus0.out_ready;
    er = (le && gv) ? 4'(1 << g) : 4'b0;
    chk("in_ready", 64'(bus0.in_ready), 64'(er));
    chk("out_valid", 64'(bus0.out_valid), 64'(m_ov));
    if (m_ov) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        chk("out_data", 64'(bus0.out_data), 64'(sb[0].d));
        chk("out_channel", 64'(bus0.out_channel), 64'(sb[0].ch));
        if (bus0.out_ready) void'(sb.pop_front());
      end
    end
    if (le && gv) begin
      e.d  = bus0.in_data[g*W +: W];
      e.ch = 2'(g);
      sb.push_back(e);
      if (bus0.mode) m_rr = 2'((g + 1) % N);
      m_ov = 1'b1;
    end else if (bus0.out_ready) begin
      m_ov = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("rr_pointer", 64'(dut0.rr_pointer_q), 64'(m_rr));
  endtask

  initial begin
    bus0.in_data   = '0;
    bus0.in_valid  = 4'hF;
    bus0.mode      = 1'b1;
    bus0.select    = '0;
    bus0.out_ready = 1'b0;
    bus1.in_data   = 24'h332211;
    bus1.in_valid  = 3'b000;
    bus1.mode      = 1'b0;
    bus1.select    = 2'd3;
    bus1.out_ready = 1'b1;
    m_ov = 1'b0;
    m_rr = 2'd0;

    // Reset state, with every channel requesting
    #12;
    chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("rst_out_data", 64'(bus0.out_data), 64'd0);
    chk("rst_out_channel", 64'(bus0.out_channel), 64'd0);
    chk("rst_in_ready", 64'(bus0.in_ready), 64'd0);
    bus0.in_valid = 4'h0;
    @(posedge clk); #1;
    reset = 1'b0;

    // 3-way instance: select=3 is out of range
    bus1.in_valid = 3'b111;
    @(negedge clk);
    chk("w3_sel3_in_ready", 64'(bus1.in_ready), 64'd0);
    @(negedge clk);
    chk("w3_sel3_out_valid", 64'(bus1.out_valid), 64'd0);
    bus1.select = 2'd2;
    @(negedge clk);
    chk("w3_sel2_in_ready", 64'(bus1.in_ready), 64'b100);
    @(negedge clk);
    chk("w3_sel2_out_valid", 64'(bus1.out_valid), 64'd1);
    chk("w3_sel2_out_data", 64'(bus1.out_data), 64'h33);
    chk("w3_sel2_out_channel", 64'(bus1.out_channel), 64'd2);
    @(posedge clk); #1;
    bus1.in_valid = 3'b000;

    // Fixed select
    bus0.mode = 1'b0;
    bus0.select = 2'd2;
    bus0.out_ready = 1'b1;
    bus0.in_data[2*W +: W] = 32'hDEADBEEF;
    bus0.in_valid = 4'b0100;
    cycle();
    bus0.in_valid = 4'b0000;
    cycle();
    bus0.in_valid = 4'b1011;
    cycle();
    cycle();

    // Round-robin fairness: 0,1,2,3,0
    bus0.mode = 1'b1;
    for (int i = 0; i < N; i++) bus0.in_data[i*W +: W] = 32'hA000_0000 + 32'(i);
    bus0.in_valid = 4'hF;
    repeat (5) cycle();
    bus0.in_valid = 4'h0;
    cycle();

    // Skip and wrap: drive pointer to 3, then 0101 -> grant 0, then 2
    bus0.in_valid = 4'b0100;
    cycle();
    bus0.in_valid = 4'b0101;
    cycle();
    cycle();
    bus0.in_valid = 4'h0;
    cycle();

    // Backpressure
    bus0.mode = 1'b0;
    bus0.select = 2'd1;
    bus0.in_data[1*W +: W] = 32'h0000_1234;
    bus0.in_valid = 4'b0010;
    cycle();
    bus0.out_ready = 1'b0;
    bus0.in_valid = 4'hF;
    repeat (5) cycle();
    bus0.select = 2'd3;
    bus0.in_data[3*W +: W] = 32'h0000_5678;
    bus0.in_valid = 4'b1000;
    bus0.out_ready = 1'b1;
    cycle();
    bus0.in_valid = 4'h0;
    cycle();

    // Random mix of modes, selects, requests and stalls
    repeat (60) begin
      bus0.mode = 1'($urandom_range(0, 1));
      bus0.select = 2'($urandom_range(0, 3));
      bus0.in_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) bus0.in_data[i*W +: W] = $urandom;
      bus0.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    bus0.in_valid = 4'h0;
    bus0.out_ready = 1'b1;
    cycle();
    cycle();

    // Reset while a word is held
    bus0.mode = 1'b1;
    bus0.in_valid = 4'hF;
    bus0.out_ready = 1'b0;
    cycle();
    cycle();
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(bus0.out_valid), 64'd0);
    chk("midrst_out_data", 64'(bus0.out_data), 64'd0);
    chk("midrst_in_ready", 64'(bus0.in_ready), 64'd0);
    sb.delete();
    m_ov = 1'b0;
    m_rr = 2'd0;
    @(posedge clk); #1;
    reset = 1'b0;
    bus0.out_ready = 1'b1;
    cycle();
    cycle();
    bus0.in_valid = 4'h0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
